// File: rtl/div_pkg.sv
// ============================================================================
// Module      : div_pkg
// Description : Shared types and sizing helpers for the sequential divider.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } div_state_t;

  localparam int c_MIN_WIDTH = 2;
  localparam int c_MAX_WIDTH = 16;

  // Counter has to hold the value WIDTH itself, hence the +1.
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage : div_pkg

`default_nettype wire

// File: rtl/div_step.sv
// ============================================================================
// Module      : div_step
// Description : One combinational restoring-division iteration (shift, trial
//               subtract, restore or keep).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module div_step #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH:0]   i_r,
  input  logic [WIDTH-1:0] i_q,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH:0]   o_r,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH:0] w_shift;
  logic [WIDTH:0] w_trial;
  logic           w_unused_r_msb;

  // The partial remainder is always below the divisor, so its top bit is
  // zero and shifting it out loses nothing.
  assign w_unused_r_msb = i_r[WIDTH];
  assign w_shift        = {i_r[WIDTH-1:0], i_q[WIDTH-1]};
  assign w_trial        = w_shift - {1'b0, i_d};

  always_comb begin
    o_r = w_shift;
    o_q = {i_q[WIDTH-2:0], 1'b0};
    if (!w_trial[WIDTH]) begin
      o_r = w_trial;
      o_q = {i_q[WIDTH-2:0], 1'b1};
    end
  end

endmodule : div_step

`default_nettype wire

// File: rtl/seq_divider.sv
// ============================================================================
// Module      : seq_divider
// Description : Sequential unsigned restoring divider, one quotient bit per
//               clock, with start/busy/done handshake and divide-by-zero flag.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module seq_divider
  import div_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int c_CNT_W = cnt_width(WIDTH);

  div_state_t         r_state;
  logic [WIDTH-1:0]   r_d;
  logic [WIDTH-1:0]   r_q;
  logic [WIDTH:0]     r_r;
  logic [c_CNT_W-1:0] r_cnt;
  logic               r_dz_pend;
  logic               r_busy;
  logic               r_done;
  logic [WIDTH-1:0]   r_quotient;
  logic [WIDTH-1:0]   r_remainder;
  logic               r_div_by_zero;

  logic [WIDTH:0]     w_r_next;
  logic [WIDTH-1:0]   w_q_next;

  div_step #(
    .WIDTH (WIDTH)
  ) u_div_step (
    .i_r (r_r),
    .i_q (r_q),
    .i_d (r_d),
    .o_r (w_r_next),
    .o_q (w_q_next)
  );

  // Result outputs are published on the edge that leaves DONE, so done and
  // the values it qualifies appear together and stay put until the next one.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= IDLE;
      r_d           <= '0;
      r_q           <= '0;
      r_r           <= '0;
      r_cnt         <= '0;
      r_dz_pend     <= 1'b0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_quotient    <= '0;
      r_remainder   <= '0;
      r_div_by_zero <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_busy <= 1'b1;
            if (divisor != '0) begin
              r_d       <= divisor;
              r_q       <= dividend;
              r_r       <= '0;
              r_cnt     <= c_CNT_W'(WIDTH);
              r_dz_pend <= 1'b0;
              r_state   <= RUN;
            end else begin
              r_d       <= '0;
              r_q       <= '1;
              r_r       <= {1'b0, dividend};
              r_cnt     <= '0;
              r_dz_pend <= 1'b1;
              r_state   <= DONE;
            end
          end
        end

        RUN: begin
          r_q   <= w_q_next;
          r_r   <= w_r_next;
          r_cnt <= r_cnt - c_CNT_W'(1);
          if (r_cnt == c_CNT_W'(1)) begin
            r_state <= DONE;
          end
        end

        DONE: begin
          r_done        <= 1'b1;
          r_busy        <= 1'b0;
          r_quotient    <= r_q;
          r_remainder   <= r_r[WIDTH-1:0];
          r_div_by_zero <= r_dz_pend;
          r_state       <= IDLE;
        end

        default: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign busy        = r_busy;
  assign done        = r_done;
  assign quotient    = r_quotient;
  assign remainder   = r_remainder;
  assign div_by_zero = r_div_by_zero;

endmodule : seq_divider

`default_nettype wire

// File: tb/tb_seq_divider.sv
// ============================================================================
// Module      : tb_seq_divider
// Description : Directed self-checking bench for seq_divider at WIDTH=4 and 8.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_seq_divider;

  logic       clk;
  logic       rst;
  logic       start;
  logic [3:0] dividend;
  logic [3:0] divisor;
  logic       busy;
  logic       done;
  logic [3:0] quotient;
  logic [3:0] remainder;
  logic       div_by_zero;

  logic       start8;
  logic [7:0] dividend8;
  logic [7:0] divisor8;
  logic       busy8;
  logic       done8;
  logic [7:0] quotient8;
  logic [7:0] remainder8;
  logic       div_by_zero8;

  int errors = 0;
  int checks = 0;

  seq_divider #(.WIDTH(4)) u_dut4 (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  seq_divider #(.WIDTH(8)) u_dut8 (
    .clk         (clk),
    .rst         (rst),
    .start       (start8),
    .dividend    (dividend8),
    .divisor     (divisor8),
    .busy        (busy8),
    .done        (done8),
    .quotient    (quotient8),
    .remainder   (remainder8),
    .div_by_zero (div_by_zero8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic wait_done(output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (done !== 1'b1 && n < 40);
  endtask

  task automatic run_op(input string tag, input logic [3:0] a, input logic [3:0] b,
                        input int eq, input int er, input int edz, input int elat);
    int n;
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    tick();
    start    = 1'b0;
    check({tag, " busy"}, 32'(busy), 1);
    wait_done(n);
    check({tag, " latency"}, n, elat);
    check({tag, " q"}, 32'(quotient), eq);
    check({tag, " r"}, 32'(remainder), er);
    check({tag, " dz"}, 32'(div_by_zero), edz);
    tick();
    check({tag, " done pulse width"}, 32'(done), 0);
  endtask

  task automatic quiet_window(input string tag);
    int seen = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (done === 1'b1) seen++;
    end
    check({tag, " no done"}, seen, 0);
    check({tag, " idle busy"}, 32'(busy), 0);
  endtask

  initial begin
    int n;
    rst       = 1'b1;
    start     = 1'b0;
    dividend  = '0;
    divisor   = '0;
    start8    = 1'b0;
    dividend8 = '0;
    divisor8  = '0;
    tick();
    tick();
    check("reset busy", 32'(busy), 0);
    check("reset done", 32'(done), 0);
    check("reset q", 32'(quotient), 0);
    check("reset r", 32'(remainder), 0);
    check("reset dz", 32'(div_by_zero), 0);
    rst = 1'b0;
    tick();

    run_op("13/3", 4'd13, 4'd3, 4, 1, 0, 5);

    // Back-to-back with start held high; operands swapped in the done cycle.
    dividend = 4'd15;
    divisor  = 4'd1;
    start    = 1'b1;
    tick();
    wait_done(n);
    check("b2b 15/1 latency", n, 5);
    check("b2b 15/1 q", 32'(quotient), 15);
    check("b2b 15/1 r", 32'(remainder), 0);
    dividend = 4'd5;
    divisor  = 4'd7;
    wait_done(n);
    check("b2b 5/7 spacing", n, 6);
    check("b2b 5/7 q", 32'(quotient), 0);
    check("b2b 5/7 r", 32'(remainder), 5);
    dividend = 4'd15;
    divisor  = 4'd15;
    wait_done(n);
    start = 1'b0;
    check("b2b 15/15 spacing", n, 6);
    check("b2b 15/15 q", 32'(quotient), 1);
    check("b2b 15/15 r", 32'(remainder), 0);
    tick();
    tick();
    check("b2b stops", 32'(busy), 0);

    run_op("9/0", 4'd9, 4'd0, 15, 9, 1, 1);
    run_op("8/2", 4'd8, 4'd2, 4, 0, 0, 5);

    // Request during RUN must be ignored; operand changes must not leak in.
    dividend = 4'd13;
    divisor  = 4'd3;
    start    = 1'b1;
    tick();
    dividend = 4'd2;
    divisor  = 4'd1;
    tick();
    start    = 1'b0;
    dividend = 4'd7;
    divisor  = 4'd5;
    wait_done(n);
    check("ignore latency", n, 4);
    check("ignore q", 32'(quotient), 4);
    check("ignore r", 32'(remainder), 1);
    quiet_window("ignore");

    // Reset in the second RUN cycle aborts without a done pulse.
    dividend = 4'd14;
    divisor  = 4'd4;
    start    = 1'b1;
    tick();
    start    = 1'b0;
    tick();
    rst      = 1'b1;
    tick();
    rst      = 1'b0;
    check("abort busy", 32'(busy), 0);
    check("abort done", 32'(done), 0);
    check("abort q", 32'(quotient), 0);
    check("abort r", 32'(remainder), 0);
    quiet_window("abort");
    run_op("14/4", 4'd14, 4'd4, 3, 2, 0, 5);

    dividend8 = 8'd255;
    divisor8  = 8'd16;
    start8    = 1'b1;
    tick();
    start8    = 1'b0;
    check("w8 busy", 32'(busy8), 1);
    n = 0;
    do begin
      tick();
      n++;
    end while (done8 !== 1'b1 && n < 40);
    check("w8 latency", n, 9);
    check("w8 q", 32'(quotient8), 15);
    check("w8 r", 32'(remainder8), 15);
    check("w8 dz", 32'(div_by_zero8), 0);

    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        if (b == 0)
          run_op($sformatf("sweep %0d/%0d", a, b), 4'(a), 4'(b), 15, a, 1, 1);
        else
          run_op($sformatf("sweep %0d/%0d", a, b), 4'(a), 4'(b), a / b, a % b, 0, 5);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_seq_divider

`default_nettype wire

// File: doc/seq_divider.md
Name: seq_divider

Overview:
Sequential unsigned restoring divider, the inverse companion of the team's shift-add multiplier datapath.
- Accepts a dividend and divisor with a start pulse.
- Iterates one shift-subtract step per clock.
- Presents quotient and remainder with a one-cycle done pulse.
- Sits beside the multiplier in the arithmetic unit and is driven by the same top-level controller.

Parameters:
WIDTH, 4, operand/quotient/remainder width in bits (legal range 2..16)

Ports:
clk  input  1  system clock; all state changes on rising edge
rst  input  1  synchronous, active-high reset
start  input  1  request; sampled only in IDLE
dividend  input  WIDTH  unsigned dividend; sampled with start
divisor  input  WIDTH  unsigned divisor; sampled with start
busy  output  1  high in RUN and DONE states
done  output  1  single-cycle pulse when results are valid
quotient  output  WIDTH  result quotient; held until next accepted start
remainder  output  WIDTH  result remainder; held until next accepted start
div_by_zero  output  1  set with done when divisor was 0; held with results

Behaviour:
- One clock (clk); reset is synchronous and active-high (rst). rst overrides all other inputs.
- Reset values: state=IDLE, busy=0, done=0, quotient=0, remainder=0, div_by_zero=0, iteration counter=0.
- FSM states: IDLE, RUN, DONE.
- IDLE with start=1 and divisor!=0:
  - Latch D=divisor, Q=dividend, R=0 ((WIDTH+1) bits); counter=WIDTH; div_by_zero<=0.
  - Go to RUN.
- IDLE with start=1 and divisor==0:
  - Go directly to DONE.
  - quotient<={WIDTH{1'b1}}, remainder<=dividend, div_by_zero<=1.
- RUN, each cycle:
  - Shift {R,Q} left by one; T = R_shifted - {1'b0,D}.
  - If T is non-negative (MSB 0): R<=T and Q[0]<=1; else R<=R_shifted and Q[0]<=0.
  - counter decrements. When counter reaches 1 (the last step), go to DONE.
  - RUN lasts exactly WIDTH cycles.
- DONE: done=1 for exactly one cycle; quotient<=Q and remainder<=R[WIDTH-1:0] are visible in the same cycle as done. Next state is IDLE.
- Latency: start accepted at edge k → done high during the cycle after edge k+WIDTH+1 (WIDTH+2 edges from acceptance to the return to IDLE). Divide-by-zero: done high after edge k+1.
- start while busy (RUN or DONE) is ignored; the operation in flight is unaffected. start held high continuously re-triggers in IDLE after each done.
- Outputs quotient/remainder/div_by_zero change only in DONE or on reset; they are stable in IDLE and RUN.
- rst asserted mid-RUN: aborts the operation next edge to reset values; no done is produced.
- Operand inputs changing during RUN have no effect; the latched copies are used.
- Results satisfy dividend == quotient*divisor + remainder and remainder < divisor for all divisor != 0.

Decomposition:
- Package div_pkg:
  - typedef enum logic [1:0] {IDLE, RUN, DONE} div_state_t
  - localparam for counter width: $clog2(WIDTH+1)
- Sub-module div_step: combinational single restoring iteration.
  - Inputs: R (WIDTH+1), Q (WIDTH), D (WIDTH).
  - Outputs: next R, next Q.
- seq_divider holds the FSM, counter, and registers, and instantiates div_step once.

Test Plan:
- WIDTH=4, dividend=13, divisor=3, start pulse → busy next cycle; done exactly 5 cycles after the accepting edge; quotient=4, remainder=1, div_by_zero=0.
- Corner values: 15/1 → q=15, r=0; 5/7 → q=0, r=5; 15/15 → q=1, r=0. Run back-to-back with start held high; each done is separated by WIDTH+2 cycles.
- 9/0 → done one cycle after acceptance; quotient=15, remainder=9, div_by_zero=1. A following 8/2 → q=4, r=0, div_by_zero cleared.
- Start 13/3, pulse start with 2/1 during RUN and change operands → result still q=4, r=1; second request not executed.
- Start 14/4, assert rst on the 2nd RUN cycle → next cycle busy=0, quotient=0, remainder=0; no done pulse. Then 14/4 → q=3, r=2.
- WIDTH=8: 255/16 → q=15, r=15, done 9 cycles after acceptance. Also run an exhaustive sweep of all 4-bit operand pairs at WIDTH=4 against the reference model dividend/divisor, dividend%divisor.
